// File: rtl/i2c_master_bitctl.sv
// rtl/i2c_master_bitctl.sv - I2C master bit/byte controller producing open-drain SCL/SDA waveforms (optional macro: I2C_CLK_STRETCH_EN)
module i2c_master_bitctl #(
    parameter int BIT_PHASES = 20
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       tick,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] tx_data,
    input  logic       tx_ack,
    output logic       done,
    output logic       err,
    output logic [7:0] rx_data,
    output logic       ack_out,
    output logic       bus_busy,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe
);

    localparam int PW = $clog2(BIT_PHASES);
    localparam logic [PW-1:0] PH_Q1   = PW'(BIT_PHASES / 4);
    localparam logic [PW-1:0] PH_Q3   = PW'(BIT_PHASES - BIT_PHASES / 4);
    localparam logic [PW-1:0] PH_SMP  = PW'(BIT_PHASES / 2 - 1);
    localparam logic [PW-1:0] PH_LAST = PW'(BIT_PHASES - 1);

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STOP,
        S_XFER,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [3:0]    slot_q, slot_d;
    logic [1:0]    cmd_q, cmd_d;
    logic [7:0]    tx_q, tx_d;
    logic          tx_ack_q, tx_ack_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;
    logic          hold_q, hold_d;
    logic          err_q, err_d;
    logic          adv;

`ifndef I2C_CLK_STRETCH_EN
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
`endif

    assign cmd_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_DONE) && err_q;
    assign rx_data   = rx_data_q;
    assign ack_out   = ack_q;
    assign bus_busy  = busy_q;

    // State and datapath registers; async reset releases both lines at once
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            slot_q    <= '0;
            cmd_q     <= CMD_START;
            tx_q      <= '0;
            tx_ack_q  <= 1'b0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            ack_q     <= 1'b1;
            busy_q    <= 1'b0;
            hold_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            slot_q    <= slot_d;
            cmd_q     <= cmd_d;
            tx_q      <= tx_d;
            tx_ack_q  <= tx_ack_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            hold_q    <= hold_d;
            err_q     <= err_d;
        end
    end

    // Line drive decode per phase, then phase/slot sequencing and command handling
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        slot_d    = slot_q;
        cmd_d     = cmd_q;
        tx_d      = tx_q;
        tx_ack_d  = tx_ack_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        ack_d     = ack_q;
        busy_d    = busy_q;
        hold_d    = hold_q;
        err_d     = err_q;
        scl_oe    = 1'b0;
        sda_oe    = 1'b0;
        adv       = 1'b0;

        case (state_q)
            S_START: begin
                if (phase_q < PH_Q1) begin
                    scl_oe = busy_q;
                end else if (phase_q >= PH_Q3) begin
                    sda_oe = 1'b1;
                end
            end
            S_STOP: begin
                if (phase_q < PH_Q1) begin
                    scl_oe = 1'b1;
                    sda_oe = 1'b1;
                end else if (phase_q < PH_Q3) begin
                    sda_oe = 1'b1;
                end
            end
            S_XFER: begin
                scl_oe = (phase_q < PH_Q1) || (phase_q >= PH_Q3);
                if (slot_q == 4'd8) begin
                    sda_oe = (cmd_q == CMD_READ) && tx_ack_q;
                end else begin
                    sda_oe = (cmd_q == CMD_WRITE) && !tx_q[7];
                end
            end
            default: begin
                scl_oe = hold_q;
            end
        endcase

        // A slave holding SCL low while we release it freezes the phase counter
`ifdef I2C_CLK_STRETCH_EN
        adv = tick && !((phase_q >= PH_Q1) && (phase_q < PH_Q3) && !scl_in && !scl_oe);
`else
        adv = tick;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cmd_d    = cmd;
                    tx_d     = tx_data;
                    tx_ack_d = tx_ack;
                    phase_d  = '0;
                    slot_d   = '0;
                    rx_sh_d  = '0;
                    err_d    = (cmd != CMD_START) && !busy_q;
                    if ((cmd != CMD_START) && !busy_q) begin
                        state_d = S_DONE;
                    end else if (cmd == CMD_START) begin
                        state_d = S_START;
                    end else if (cmd == CMD_STOP) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_XFER;
                    end
                end
            end
            S_START, S_STOP: begin
                if (adv) begin
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        state_d = S_DONE;
                        busy_d  = (state_q == S_START);
                        hold_d  = (state_q == S_START);
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
            end
            S_XFER: begin
                if (adv) begin
                    if (phase_q == PH_SMP) begin
                        if (slot_q == 4'd8) begin
                            if (cmd_q == CMD_WRITE) begin
                                ack_d = sda_in;
                            end
                        end else if (cmd_q == CMD_READ) begin
                            rx_sh_d = {rx_sh_q[6:0], sda_in};
                        end
                    end
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        if (slot_q == 4'd8) begin
                            state_d = S_DONE;
                            hold_d  = 1'b1;
                            if (cmd_q == CMD_READ) begin
                                rx_data_d = rx_sh_q;
                            end
                        end else begin
                            slot_d = slot_q + 4'd1;
                            tx_d   = {tx_q[6:0], 1'b0};
                        end
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_master_bitctl.sv
// tb/tb_i2c_master_bitctl.sv - directed table-driven bench for i2c_master_bitctl with a small I2C slave model
module tb_i2c_master_bitctl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd = 2'b00;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ack = 1'b0;
    logic       done, err;
    logic [7:0] rx_data;
    logic       ack_out, bus_busy;
    logic       scl_oe, sda_oe;
    logic       scl_line, sda_line;
    logic       slave_scl_low = 1'b0;
    logic       slave_sda_low;
    int         slave_mode = 0;
    logic [7:0] slave_byte = 8'h00;

    int         checks = 0;
    int         failures = 0;

    int         fall_cnt = 0;
    int         rise_cnt = 0;
    logic [8:0] rise_sh = '0;
    logic       saw_oe = 1'b0;
    logic       sda_rise_scl = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;

    assign scl_line = ~(scl_oe | slave_scl_low);
    assign sda_line = ~(sda_oe | slave_sda_low);

    i2c_master_bitctl #(.BIT_PHASES(20)) dut (
        .clkin     (clk),
        .rst       (rst),
        .tick      (tick),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .tx_data   (tx_data),
        .tx_ack    (tx_ack),
        .done      (done),
        .err       (err),
        .rx_data   (rx_data),
        .ack_out   (ack_out),
        .bus_busy  (bus_busy),
        .scl_in    (scl_line),
        .sda_in    (sda_line),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe)
    );

    always #20 clk = ~clk;

    // one-cycle tick every 12 clocks
    initial begin
        forever begin
            repeat (11) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    // slave: ACK after 8th SCL fall (mode 1), or serve slave_byte MSB first (mode 2)
    always_comb begin
        slave_sda_low = 1'b0;
        if (slave_mode == 1) begin
            slave_sda_low = (fall_cnt == 8);
        end else if (slave_mode == 2 && fall_cnt < 8) begin
            slave_sda_low = ~slave_byte[3'(7 - fall_cnt)];
        end
    end

    // bus monitor, cleared when a command is about to be accepted
    initial begin
        forever begin
            @(negedge clk);
            if (cmd_valid && cmd_ready) begin
                fall_cnt     = 0;
                rise_cnt     = 0;
                rise_sh      = '0;
                saw_oe       = 1'b0;
                sda_rise_scl = 1'b0;
            end else begin
                if (!prev_scl && scl_line) begin
                    rise_cnt = rise_cnt + 1;
                    rise_sh  = {rise_sh[7:0], sda_line};
                end
                if (prev_scl && !scl_line) fall_cnt = fall_cnt + 1;
                if (!prev_sda && sda_line) sda_rise_scl = scl_line;
                if (scl_oe || sda_oe) saw_oe = 1'b1;
            end
            prev_scl = scl_line;
            prev_sda = sda_line;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic a);
        @(posedge clk);
        #1;
        cmd       = c;
        tx_data   = d;
        tx_ack    = a;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        tx_data   = ~d;
    endtask

    task automatic wait_done(input int hold_at, input int hold_len, output int ticks, output logic got_err);
        ticks   = 0;
        got_err = 1'b0;
        if (done) begin
            got_err = err;
            return;
        end
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            if (tick) ticks = ticks + 1;
            #1;
            if (hold_len > 0 && ticks == hold_at) slave_scl_low = 1'b1;
            if (hold_len > 0 && ticks == hold_at + hold_len) slave_scl_low = 1'b0;
            if (done) begin
                got_err = err;
                return;
            end
        end
        ticks = -1;
    endtask

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] data;
        logic       txack;
        int         smode;
        logic [7:0] sbyte;
        logic       err;
        int         ticks;
        logic       busy;
        logic       ack;
        logic [7:0] rx;
        logic       scl;
        logic       chk_bits;
        logic [7:0] bits;
        logic       b9;
        logic       chk_stop;
        logic       chk_quiet;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int   t;
        int   n;
        logic e;
        int   exp_stretch;

        //          cmd    data   txa  sm  sbyte  err  ticks busy ack  rx     scl  bits bval   b9   stop quiet
        vecs[0]  = '{2'b00, 8'h00, 1'b0, 0, 8'h00, 1'b0, 20,  1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'b10, 8'hA4, 1'b0, 1, 8'h00, 1'b0, 180, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA4, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{2'b10, 8'h3C, 1'b0, 0, 8'h00, 1'b0, 180, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{2'b00, 8'h00, 1'b0, 0, 8'h00, 1'b0, 20,  1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{2'b11, 8'h00, 1'b0, 2, 8'h5A, 1'b0, 180, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{2'b01, 8'h00, 1'b0, 0, 8'h00, 1'b0, 20,  1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{2'b10, 8'h11, 1'b0, 0, 8'h00, 1'b1, 0,   1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{2'b11, 8'h00, 1'b1, 0, 8'h00, 1'b1, 0,   1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{2'b01, 8'h00, 1'b0, 0, 8'h00, 1'b1, 0,   1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{2'b00, 8'h00, 1'b0, 0, 8'h00, 1'b0, 20,  1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{2'b11, 8'h00, 1'b1, 2, 8'hA5, 1'b0, 180, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{2'b01, 8'h00, 1'b0, 0, 8'h00, 1'b0, 20,  1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_scl_oe", scl_oe, 1'b0);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_ack_out", ack_out, 1'b1);
        check("rst_bus_busy", bus_busy, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        #5;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            slave_mode = vecs[i].smode;
            slave_byte = vecs[i].sbyte;
            issue(vecs[i].cmd, vecs[i].data, vecs[i].txack);
            wait_done(0, 0, t, e);
            check($sformatf("v%0d_ticks", i), t, vecs[i].ticks);
            check($sformatf("v%0d_err", i), e, vecs[i].err);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_width", i), done, 1'b0);
            check($sformatf("v%0d_cmd_ready", i), cmd_ready, 1'b1);
            check($sformatf("v%0d_bus_busy", i), bus_busy, vecs[i].busy);
            check($sformatf("v%0d_ack_out", i), ack_out, vecs[i].ack);
            check($sformatf("v%0d_rx_data", i), rx_data, vecs[i].rx);
            check($sformatf("v%0d_scl_oe", i), scl_oe, vecs[i].scl);
            if (vecs[i].chk_bits) begin
                check($sformatf("v%0d_scl_rises", i), rise_cnt, 9);
                check($sformatf("v%0d_sda_bits", i), rise_sh[8:1], vecs[i].bits);
                check($sformatf("v%0d_sda_slot9", i), rise_sh[0], vecs[i].b9);
            end
            if (vecs[i].chk_stop) begin
                check($sformatf("v%0d_stop_sda_rise_scl_high", i), sda_rise_scl, 1'b1);
                check($sformatf("v%0d_stop_sda_oe", i), sda_oe, 1'b0);
            end
            if (vecs[i].chk_quiet) begin
                check($sformatf("v%0d_no_line_activity", i), saw_oe, 1'b0);
            end
        end

        // reset during ph7 of slot 4 of a WRITE
        slave_mode = 0;
        issue(2'b00, 8'h00, 1'b0);
        wait_done(0, 0, t, e);
        check("rs_start_ticks", t, 20);
        issue(2'b10, 8'h00, 1'b0);
        n = 0;
        for (int c = 0; c < 2000 && n < 67; c++) begin
            @(posedge clk);
            if (tick) n = n + 1;
        end
        #1;
        check("rs_reach_ph7", n, 67);
        check("rs_pre_sda_oe", sda_oe, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rs_async_scl_oe", scl_oe, 1'b0);
        check("rs_async_sda_oe", sda_oe, 1'b0);
        check("rs_async_cmd_ready", cmd_ready, 1'b1);
        check("rs_async_bus_busy", bus_busy, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        check("rs_ack_out", ack_out, 1'b1);
        issue(2'b00, 8'h00, 1'b0);
        wait_done(0, 0, t, e);
        check("rs_restart_ticks", t, 20);
        check("rs_restart_err", e, 1'b0);
        @(posedge clk);
        #1;
        check("rs_restart_busy", bus_busy, 1'b1);

        // slave holds SCL low for 50 ticks from ph5 of slot 3
`ifdef I2C_CLK_STRETCH_EN
        exp_stretch = 230;
`else
        exp_stretch = 180;
`endif
        issue(2'b10, 8'h96, 1'b0);
        wait_done(45, 50, t, e);
        check("st_ticks", t, exp_stretch);
        check("st_err", e, 1'b0);
        @(posedge clk);
        #1;
        check("st_ack_out", ack_out, 1'b1);
        check("st_scl_low", scl_oe, 1'b1);
`ifdef I2C_CLK_STRETCH_EN
        check("st_sda_bits", rise_sh[8:1], 8'h96);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
